// File: rtl/flash_responder.sv
// flash_responder: SPI (mode 0) serial-flash read responder.
// Serves READ (0x03): 24-bit address, then a gapless byte stream from a
// byte-wide backing store with an auto-incrementing, wrapping address.
// Optional feature macro: FLASH_RESPONDER_FASTREAD_EN also accepts FAST READ
// (0x0B), which inserts 8 dummy clocks between the address and the data.
module flash_responder #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flashClk,
  input  logic                 flashCs,
  input  logic                 flashMosi,
  output logic                 flashMiso,
  output logic [ADDR_BITS-1:0] memAddr,
  output logic                 memRd,
  input  logic [7:0]           memData,
  output logic                 busy,
  output logic                 cmdErr
);

  localparam int CW = $clog2(ADDR_BITS);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  state_t state;

  logic [1:0]           clkSync, csSync, mosiSync;
  logic                 clkPrev;
  logic [1:0]           fill;     // counts synchronizer refill after reset
  logic                 armed;    // CS has been seen high since reset
  logic [CW-1:0]        bitCnt;
  logic [6:0]           cmdSh;
  logic [ADDR_BITS-2:0] addrSh;
  logic [7:0]           txSh;
  logic                 sclkRise, sclkFall, csHigh, mosiBit, cmdFast;
  logic [7:0]           cmdByte;
`ifdef FLASH_RESPONDER_FASTREAD_EN
  logic                 fastRd;
`endif

  assign sclkRise = clkSync[1] & ~clkPrev;
  assign sclkFall = ~clkSync[1] & clkPrev;
  assign csHigh   = csSync[1];
  assign mosiBit  = mosiSync[1];
  assign cmdByte  = {cmdSh, mosiBit};
`ifdef FLASH_RESPONDER_FASTREAD_EN
  assign cmdFast  = (cmdByte == 8'h0B);
`else
  assign cmdFast  = 1'b0;
`endif

  // Synchronize the SPI pins and track whether CS was idle after reset, so a
  // transaction already underway when reset drops is not mistaken for a new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync  <= 2'b00;
      csSync   <= 2'b11;
      mosiSync <= 2'b00;
      clkPrev  <= 1'b0;
      fill     <= 2'd0;
      armed    <= 1'b0;
    end else begin
      clkSync  <= {clkSync[0], flashClk};
      csSync   <= {csSync[0], flashCs};
      mosiSync <= {mosiSync[0], flashMosi};
      clkPrev  <= clkSync[1];
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && csSync[1]) armed <= 1'b1;
    end
  end

  // Protocol FSM with registered outputs; CS high aborts from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitCnt    <= '0;
      cmdSh     <= '0;
      addrSh    <= '0;
      txSh      <= '0;
      memAddr   <= '0;
      memRd     <= 1'b0;
      flashMiso <= 1'b0;
      busy      <= 1'b0;
      cmdErr    <= 1'b0;
`ifdef FLASH_RESPONDER_FASTREAD_EN
      fastRd    <= 1'b0;
`endif
    end else begin
      memRd  <= 1'b0;
      cmdErr <= 1'b0;
      // Store data is valid the clk after the strobe; the next fall drives bit 7.
      if (memRd) txSh <= memData;
      if (state != DATA) flashMiso <= 1'b0;
      if (state != IDLE && csHigh) begin
        state     <= IDLE;
        bitCnt    <= '0;
        flashMiso <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fill == 2'd2 && !csHigh) begin
              bitCnt <= '0;
              if (armed) begin
                state <= CMD;
                busy  <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          CMD: begin
            if (sclkRise) begin
              cmdSh <= cmdByte[6:0];
              if (bitCnt == CW'(7)) begin
                bitCnt <= '0;
                if (cmdByte == 8'h03 || cmdFast) begin
                  state <= ADDR;
`ifdef FLASH_RESPONDER_FASTREAD_EN
                  fastRd <= cmdFast;
`endif
                end else begin
                  state  <= IGNORE;
                  busy   <= 1'b0;
                  cmdErr <= 1'b1;
                end
              end else begin
                bitCnt <= bitCnt + CW'(1);
              end
            end
          end
          ADDR: begin
            if (sclkRise) begin
              addrSh <= {addrSh[ADDR_BITS-3:0], mosiBit};
              if (bitCnt == CW'(ADDR_BITS-1)) begin
                bitCnt  <= '0;
                memAddr <= {addrSh, mosiBit};
                memRd   <= 1'b1;
`ifdef FLASH_RESPONDER_FASTREAD_EN
                state   <= fastRd ? DUMMY : DATA;
`else
                state   <= DATA;
`endif
              end else begin
                bitCnt <= bitCnt + CW'(1);
              end
            end
          end
          DUMMY: begin
            // First byte was already fetched; just let 8 clocks go by.
            if (sclkRise) begin
              if (bitCnt == CW'(7)) begin
                bitCnt <= '0;
                state  <= DATA;
              end else begin
                bitCnt <= bitCnt + CW'(1);
              end
            end
          end
          DATA: begin
            if (sclkFall) begin
              flashMiso <= txSh[7];
              txSh      <= {txSh[6:0], 1'b0};
            end
            // Prefetch the next byte as bit 0 is sampled, keeping the stream gapless.
            if (sclkRise) begin
              if (bitCnt == CW'(7)) begin
                bitCnt  <= '0;
                memAddr <= memAddr + ADDR_BITS'(1);
                memRd   <= 1'b1;
              end else begin
                bitCnt <= bitCnt + CW'(1);
              end
            end
          end
          IGNORE: ;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// tb_flash_responder: scoreboard bench for flash_responder (SPI read responder).
module tb_flash_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        flashClk = 1'b0, flashCs = 1'b1, flashMosi = 1'b0;
  logic        flashMiso, memRd, busy, cmdErr;
  logic [23:0] memAddr;
  logic [7:0]  memData;
  logic [7:0]  store [256];

  int errors = 0, checks = 0;
  int rdCnt = 0, errHi = 0;
  bit chkBusy = 0, busyLow = 0, chkMiso = 0, misoHigh = 0;
  logic [7:0]  expQ [$];
  logic [23:0] lastAddr;

  assign memData = store[memAddr[7:0]];

  always #5 clk = ~clk;

  flash_responder #(.ADDR_BITS(24)) dut (
    .clk(clk), .rst(rst), .flashClk(flashClk), .flashCs(flashCs),
    .flashMosi(flashMosi), .flashMiso(flashMiso), .memAddr(memAddr),
    .memRd(memRd), .memData(memData), .busy(busy), .cmdErr(cmdErr)
  );

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && memRd) rdCnt++;
    if (cmdErr) errHi++;
    if (chkBusy && !busy) busyLow = 1;
    if (chkMiso && flashMiso) misoHigh = 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic csLow();
    flashCs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csRaise();
    flashCs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Mode 0 transfer of the top n bits of tx; MISO sampled just before each rise.
  task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      flashMosi = tx[i];
      repeat (5) @(negedge clk);
      rx[i] = flashMiso;
      if (i == 0) lastAddr = memAddr;
      flashClk = 1'b1;
      repeat (5) @(negedge clk);
      flashClk = 1'b0;
    end
    flashMosi = 1'b0;
  endtask

  task automatic header(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    xfer(cmd, 8, rx);
    xfer(addr[23:16], 8, rx);
    xfer(addr[15:8], 8, rx);
    xfer(addr[7:0], 8, rx);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (memAddr !== 24'h0) begin errors++; $display("FAIL reset_memAddr got %h want 000000", memAddr); end
    checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL reset_memRd got %b want 0", memRd); end
    checks++; if (flashMiso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", flashMiso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cmdErr !== 1'b0) begin errors++; $display("FAIL reset_cmdErr got %b want 0", cmdErr); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_read();
    logic [7:0] rx, exp;
    int rdBase;
    for (int i = 0; i < 3; i++) expQ.push_back(store[8'h10 + i]);
    csLow();
    rdBase = rdCnt; busyLow = 0; chkBusy = 1;
    header(8'h03, 24'h000010);
    for (int k = 0; k < 3; k++) begin
      xfer(8'h00, 8, rx);
      exp = expQ.pop_front();
      checks++; if (rx !== exp) begin errors++; $display("FAIL read_byte%0d got %h want %h", k, rx, exp); end
    end
    chkBusy = 0;
    checks++; if (lastAddr !== 24'h000012) begin errors++; $display("FAIL read_memAddr got %h want 000012", lastAddr); end
    checks++; if (busyLow !== 0) begin errors++; $display("FAIL read_busy dropped low got %0d want 0", busyLow); end
    checks++; if (rdCnt - rdBase !== 4) begin errors++; $display("FAIL read_rdCount got %0d want 4", rdCnt - rdBase); end
    flashCs = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_cs got %b want 0", busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] rx, exp;
    expQ.push_back(store[8'hFF]);
    expQ.push_back(store[8'h00]);
    csLow();
    header(8'h03, 24'hFFFFFF);
    for (int k = 0; k < 2; k++) begin
      xfer(8'h00, 8, rx);
      exp = expQ.pop_front();
      checks++; if (rx !== exp) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", k, rx, exp); end
    end
    checks++; if (lastAddr !== 24'h000000) begin errors++; $display("FAIL wrap_memAddr got %h want 000000", lastAddr); end
    csRaise();
  endtask

  task automatic test_badcmd();
    logic [7:0] rx;
    int rdBase, errBase;
    csLow();
    rdBase = rdCnt; errBase = errHi;
    xfer(8'h9F, 8, rx);
    misoHigh = 0; chkMiso = 1;
    repeat (4) @(negedge clk);
    checks++; if (errHi - errBase !== 1) begin errors++; $display("FAIL badcmd_cmdErr cycles got %0d want 1", errHi - errBase); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy got %b want 0", busy); end
    for (int k = 0; k < 4; k++) xfer(8'h5A, 8, rx);
    chkMiso = 0;
    checks++; if (misoHigh !== 0) begin errors++; $display("FAIL badcmd_miso seen high got %0d want 0", misoHigh); end
    checks++; if (rdCnt - rdBase !== 0) begin errors++; $display("FAIL badcmd_memRd got %0d want 0", rdCnt - rdBase); end
    csRaise();
  endtask

  task automatic test_abort();
    logic [7:0] rx, exp;
    int rdBase;
    csLow();
    rdBase = rdCnt;
    xfer(8'h03, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h00, 4, rx);
    flashCs = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (rdCnt - rdBase !== 0) begin errors++; $display("FAIL abort_memRd got %0d want 0", rdCnt - rdBase); end
    expQ.push_back(store[8'h04]);
    csLow();
    header(8'h03, 24'h000004);
    xfer(8'h00, 8, rx);
    exp = expQ.pop_front();
    checks++; if (rx !== exp) begin errors++; $display("FAIL abort_next_byte got %h want %h", rx, exp); end
    csRaise();
  endtask

  task automatic test_rst_mid();
    logic [7:0] rx, exp;
    int rdBase;
    expQ.push_back(store[8'h10]);
    csLow();
    header(8'h03, 24'h000010);
    xfer(8'h00, 8, rx);
    exp = expQ.pop_front();
    checks++; if (rx !== exp) begin errors++; $display("FAIL rstmid_byte0 got %h want %h", rx, exp); end
    xfer(8'h00, 4, rx);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (memAddr !== 24'h0) begin errors++; $display("FAIL rstmid_memAddr got %h want 000000", memAddr); end
    checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL rstmid_memRd got %b want 0", memRd); end
    checks++; if (flashMiso !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b want 0", flashMiso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    rst = 1'b0;
    rdBase = rdCnt;
    xfer(8'h00, 4, rx);
    xfer(8'h03, 8, rx);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_ignore_busy got %b want 0", busy); end
    csRaise();
    checks++; if (rdCnt - rdBase !== 0) begin errors++; $display("FAIL rstmid_memRd_count got %0d want 0", rdCnt - rdBase); end
    expQ.push_back(store[8'h11]);
    csLow();
    header(8'h03, 24'h000011);
    xfer(8'h00, 8, rx);
    exp = expQ.pop_front();
    checks++; if (rx !== exp) begin errors++; $display("FAIL rstmid_next_byte got %h want %h", rx, exp); end
    csRaise();
  endtask

  task automatic test_fastread();
    logic [7:0] rx;
    int rdBase, errBase;
`ifdef FLASH_RESPONDER_FASTREAD_EN
    logic [7:0] exp;
`endif
    csLow();
    rdBase = rdCnt; errBase = errHi;
`ifdef FLASH_RESPONDER_FASTREAD_EN
    expQ.push_back(store[8'h20]);
    header(8'h0B, 24'h000020);
    xfer(8'h00, 8, rx);
    xfer(8'h00, 8, rx);
    exp = expQ.pop_front();
    checks++; if (rx !== exp) begin errors++; $display("FAIL fast_byte got %h want %h", rx, exp); end
    checks++; if (errHi - errBase !== 0) begin errors++; $display("FAIL fast_cmdErr got %0d want 0", errHi - errBase); end
`else
    xfer(8'h0B, 8, rx);
    misoHigh = 0; chkMiso = 1;
    xfer(8'h00, 8, rx); xfer(8'h00, 8, rx); xfer(8'h20, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h00, 8, rx);
    chkMiso = 0;
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL fast_off_byte got %h want 00", rx); end
    checks++; if (errHi - errBase !== 1) begin errors++; $display("FAIL fast_off_cmdErr got %0d want 1", errHi - errBase); end
    checks++; if (misoHigh !== 0) begin errors++; $display("FAIL fast_off_miso seen high got %0d want 0", misoHigh); end
    checks++; if (rdCnt - rdBase !== 0) begin errors++; $display("FAIL fast_off_memRd got %0d want 0", rdCnt - rdBase); end
`endif
    csRaise();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) store[i] = 8'(i * 37 + 11);
    store[8'h10] = 8'hA5; store[8'h11] = 8'h3C; store[8'h12] = 8'hFF;
    store[8'hFF] = 8'h81; store[8'h00] = 8'h7E; store[8'h04] = 8'h44;
    store[8'h20] = 8'hC3;
    test_reset();
    test_read();
    test_wrap();
    test_badcmd();
    test_abort();
    test_rst_mid();
    test_fastread();
    checks++; if (expQ.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", expQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
